// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check sequencer.
// The state encoding is exported so a debug status register can show it.
package sysid_check_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_RD_ID  = 4'd1,
    ST_LAT_ID = 4'd2,
    ST_RD_TS  = 4'd3,
    ST_LAT_TS = 4'd4,
    ST_CMP    = 4'd5,
    ST_TMO    = 4'd6,
    ST_RETRY  = 4'd7,
    ST_PASS   = 4'd8,
    ST_FAIL   = 4'd9
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int TMO_CNT_W   = 16;
  localparam int RETRY_CNT_W = 4;
  localparam int GAP_CNT_W   = 8;

  function automatic logic is_rd_state(input state_t s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/sysid_read_port.sv
// One Avalon-MM read: strobe held through waitrequest, stall timeout, and
// fixed-latency data return. Reused for both sysid words.
module sysid_read_port
  import sysid_check_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic        i_addr,
  output logic        o_read,
  output logic        o_address,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata,
  output logic        o_accepted,
  output logic        o_data_valid,
  output logic [31:0] o_data,
  output logic        o_timed_out
);

  localparam int SR_W = (READ_LATENCY > 0) ? READ_LATENCY : 1;
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic                 r_read;
  logic                 r_address;
  logic [TMO_CNT_W-1:0] r_tmo_cnt;
  logic [SR_W-1:0]      r_lat_sr;
  logic                 w_stall;

  assign w_stall     = r_read & i_waitrequest;
  assign o_accepted  = r_read & ~i_waitrequest;
  assign o_timed_out = w_stall & (r_tmo_cnt == TMO_LAST);
  assign o_read      = r_read;
  assign o_address   = r_address;

  // The strobe drops on the edge that samples acceptance, so one beat per start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_read    <= 1'b0;
      r_address <= SYSID_ADDR_ID;
      r_tmo_cnt <= '0;
    end else if (i_start) begin
      r_read    <= 1'b1;
      r_address <= i_addr;
      r_tmo_cnt <= '0;
    end else if (o_accepted || o_timed_out) begin
      r_read    <= 1'b0;
    end else if (w_stall) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_sr <= '0;
    end else begin
      r_lat_sr <= SR_W'({r_lat_sr, o_accepted});
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      // Zero-latency data is only valid in the accept cycle, so hold it here.
      logic [31:0] r_data;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_data <= '0;
        end else if (o_accepted) begin
          r_data <= i_readdata;
        end
      end
      assign o_data_valid = r_lat_sr[0];
      assign o_data       = r_data;
    end else begin : g_latn
      assign o_data_valid = r_lat_sr[SR_W-1];
      assign o_data       = i_readdata;
    end
  endgenerate

endmodule

// File: rtl/sysid_check_sequencer.sv
// Reads the sysid ID and timestamp words after reset, compares them with the
// build-time values, retries on mismatch/timeout and gates the peripheral reset.
module sysid_check_sequencer
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h52FD_3885,
  parameter int          READ_LATENCY       = 1,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3,
  parameter int          RETRY_GAP          = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  input  logic        recheck,
  output logic        busy,
  output logic        check_done,
  output logic        check_pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic        periph_reset_n,
  output state_t      dbg_state
);

  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);
  localparam logic [GAP_CNT_W-1:0]   GAP_LAST  = GAP_CNT_W'(RETRY_GAP - 1);

  state_t                 r_state;
  state_t                 r_next;
  logic [RETRY_CNT_W-1:0] r_retry_cnt;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic [31:0]            r_captured_id;
  logic [31:0]            r_captured_ts;
  logic                   r_id_mismatch;
  logic                   r_ts_mismatch;
  logic                   r_timeout;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_periph_reset_n;

  logic                   w_start;
  logic                   w_addr;
  logic                   w_accepted;
  logic                   w_data_valid;
  logic [31:0]            w_data;
  logic                   w_timed_out;
  logic                   w_id_ok;
  logic                   w_ts_ok;
  logic                   w_cap_id;
  logic                   w_cap_ts;
  logic                   w_clear_flags;
  logic                   w_retry_inc;
  logic                   w_retry_clr;

  assign w_id_ok = (r_captured_id == EXPECTED_ID);
  assign w_ts_ok = (r_captured_ts == EXPECTED_TIMESTAMP);

  sysid_read_port #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_port (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_start       (w_start),
    .i_addr        (w_addr),
    .o_read        (sysid_read),
    .o_address     (sysid_address),
    .i_waitrequest (sysid_waitrequest),
    .i_readdata    (sysid_readdata),
    .o_accepted    (w_accepted),
    .o_data_valid  (w_data_valid),
    .o_data        (w_data),
    .o_timed_out   (w_timed_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_START;
    end else begin
      r_state <= r_next;
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      ST_START:  r_next = ST_RD_ID;
      ST_RD_ID: begin
        if (w_timed_out)     r_next = ST_TMO;
        else if (w_accepted) r_next = ST_LAT_ID;
      end
      ST_LAT_ID: if (w_data_valid) r_next = ST_RD_TS;
      ST_RD_TS: begin
        if (w_timed_out)     r_next = ST_TMO;
        else if (w_accepted) r_next = ST_LAT_TS;
      end
      ST_LAT_TS: if (w_data_valid) r_next = ST_CMP;
      ST_CMP:    r_next = (w_id_ok && w_ts_ok) ? ST_PASS : ST_RETRY;
      ST_TMO:    r_next = ST_RETRY;
      ST_RETRY: begin
        if (r_retry_cnt >= RETRY_MAX)   r_next = ST_FAIL;
        else if (r_gap_cnt == GAP_LAST) r_next = ST_RD_ID;
      end
      ST_PASS:   if (recheck) r_next = ST_RD_ID;
      ST_FAIL:   if (recheck) r_next = ST_RD_ID;
      default:   r_next = ST_START;
    endcase
  end

  // Read starts are issued one cycle early so the registered strobe lines up with RD states.
  always_comb begin
    w_start       = is_rd_state(r_next) && (r_next != r_state);
    w_addr        = (r_next == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    w_cap_id      = (r_state == ST_LAT_ID) && w_data_valid;
    w_cap_ts      = (r_state == ST_LAT_TS) && w_data_valid;
    w_clear_flags = (r_next == ST_RD_ID) &&
                    ((r_state == ST_RETRY) || (r_state == ST_PASS) || (r_state == ST_FAIL));
    w_retry_inc   = (r_state == ST_RETRY) && (r_next == ST_RD_ID);
    w_retry_clr   = ((r_state == ST_PASS) || (r_state == ST_FAIL)) && (r_next == ST_RD_ID);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_captured_id <= '0;
      r_captured_ts <= '0;
    end else begin
      if (w_cap_id) r_captured_id <= w_data;
      if (w_cap_ts) r_captured_ts <= w_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_mismatch <= 1'b0;
      r_ts_mismatch <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (w_clear_flags) begin
      r_id_mismatch <= 1'b0;
      r_ts_mismatch <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (r_state == ST_CMP) begin
      r_id_mismatch <= ~w_id_ok;
      r_ts_mismatch <= ~w_ts_ok;
    end else if (r_state == ST_TMO) begin
      r_timeout     <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retry_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_retry_clr)      r_retry_cnt <= '0;
      else if (w_retry_inc) r_retry_cnt <= r_retry_cnt + 1'b1;
      r_gap_cnt <= (r_state == ST_RETRY) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  // Status bits follow the next state so they are zero while reset holds START.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_periph_reset_n <= 1'b0;
    end else begin
      r_busy           <= (r_next != ST_PASS) && (r_next != ST_FAIL);
      r_done           <= (r_next == ST_PASS) || (r_next == ST_FAIL);
      r_pass           <= (r_next == ST_PASS);
      r_periph_reset_n <= r_periph_reset_n | (r_state == ST_PASS);
    end
  end

  assign busy           = r_busy;
  assign check_done     = r_done;
  assign check_pass     = r_pass;
  assign id_mismatch    = r_id_mismatch;
  assign ts_mismatch    = r_ts_mismatch;
  assign timeout        = r_timeout;
  assign captured_id    = r_captured_id;
  assign captured_ts    = r_captured_ts;
  assign periph_reset_n = r_periph_reset_n;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Directed bench for the sysid check sequencer: a latency-1 slave model,
// a read/result scoreboard and per-scenario directed checks.
module tb_sysid_check_sequencer;
  import sysid_check_pkg::*;

  localparam logic [31:0] GOOD_ID = 32'h0000_0000;
  localparam logic [31:0] GOOD_TS = 32'h52FD_3885;
  localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        waitrequest = 1'b0;
  logic        recheck = 1'b0;
  logic [31:0] readdata = JUNK;
  logic        sysid_address, sysid_read, busy, check_done, check_pass;
  logic        id_mismatch, ts_mismatch, timeout, periph_reset_n;
  logic [31:0] captured_id, captured_ts;
  state_t      dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  logic [0:0]  exp_addr_q[$];
  logic [67:0] exp_res_q[$];

  logic [31:0] slave_id = GOOD_ID;
  int          ts_bad_attempts = 0;
  int          id_reads = 0;

  always #5 clock = ~clock;

  sysid_check_sequencer dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .sysid_address     (sysid_address),
    .sysid_read        (sysid_read),
    .sysid_waitrequest (waitrequest),
    .sysid_readdata    (readdata),
    .recheck           (recheck),
    .busy              (busy),
    .check_done        (check_done),
    .check_pass        (check_pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout           (timeout),
    .captured_id       (captured_id),
    .captured_ts       (captured_ts),
    .periph_reset_n    (periph_reset_n),
    .dbg_state         (dbg_state)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] res(input logic pass, input logic idm, input logic tsm,
                                      input logic tmo, input logic [31:0] cid,
                                      input logic [31:0] cts);
    return {pass, idm, tsm, tmo, cid, cts};
  endfunction

  // Slave model: data appears one cycle after the accepting edge.
  always @(negedge clock) begin : slave_blk
    logic acc;
    logic a;
    acc = sysid_read && !waitrequest;
    a   = sysid_address;
    @(posedge clock);
    #1;
    if (acc && reset_n) begin
      if (!a) begin
        id_reads++;
        readdata = slave_id;
      end else begin
        readdata = (id_reads <= ts_bad_attempts) ? ~GOOD_TS : GOOD_TS;
      end
    end else begin
      readdata = JUNK;
    end
  end

  logic prev_done = 1'b0;
  int   cyc = 0;
  int   last_ts_cyc = -1;
  logic gap_check_en = 1'b0;

  always @(negedge clock) begin : monitor_blk
    logic [0:0]  ea;
    logic [67:0] er;
    cyc++;
    if (sysid_read && !waitrequest) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_read", 80'(1), 80'(0));
      end else begin
        ea = exp_addr_q.pop_front();
        check("read_addr", 80'(sysid_address), 80'(ea));
      end
      if (gap_check_en) begin
        if (!sysid_address && last_ts_cyc >= 0) begin
          n_checks++;
          if (cyc - last_ts_cyc - 1 < 16) begin
            n_bad++;
            $display("FAIL retry_gap: got %0d idle cycles expected >=16", cyc - last_ts_cyc - 1);
          end
        end
        if (sysid_address) last_ts_cyc = cyc;
      end
    end
    if (check_done && !prev_done) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_done", 80'(1), 80'(0));
      end else begin
        er = exp_res_q.pop_front();
        check("result", 80'({check_pass, id_mismatch, ts_mismatch, timeout,
                             captured_id, captured_ts}), 80'(er));
      end
    end
    prev_done = check_done;
  end

  function automatic logic [79:0] all_outputs();
    return 80'({sysid_read, sysid_address, busy, check_done, check_pass, id_mismatch,
                ts_mismatch, timeout, periph_reset_n, captured_id, captured_ts});
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    recheck     = 1'b0;
    waitrequest = 1'b0;
    id_reads    = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", all_outputs(), 80'(0));
    check("reset_state", 80'(dbg_state), 80'(ST_START));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!check_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!check_done) check("done_wait_expired", 80'(0), 80'(1));
  endtask

  task automatic pulse_recheck();
    @(posedge clock);
    #1;
    recheck = 1'b1;
    @(posedge clock);
    #1;
    recheck = 1'b0;
  endtask

  task automatic push_attempts(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(SYSID_ADDR_ID);
      exp_addr_q.push_back(SYSID_ADDR_TS);
    end
  endtask

  initial begin
    int stalls;
    int n;

    // Matching slave: pass and peripheral reset release shortly after reset.
    slave_id = GOOD_ID;
    ts_bad_attempts = 0;
    push_attempts(1);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    do_reset();
    repeat (10) @(posedge clock);
    #1;
    check("t1_periph_reset_n", 80'(periph_reset_n), 80'(1));
    check("t1_pass_busy", 80'({check_pass, check_done, busy}), 80'(3'b110));

    // Wrong ID word: four attempts then FAIL with the last attempt's flags.
    slave_id = 32'h0000_0001;
    last_ts_cyc = -1;
    gap_check_en = 1'b1;
    push_attempts(4);
    exp_res_q.push_back(res(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, GOOD_TS));
    do_reset();
    wait_done(300);
    @(negedge clock);
    gap_check_en = 1'b0;
    check("t2_periph_held", 80'(periph_reset_n), 80'(0));
    check("t2_fail_status", 80'({check_done, check_pass, busy}), 80'(3'b100));
    check("t2_id_reads", 80'(id_reads), 80'(4));

    // recheck from FAIL with a corrected slave.
    slave_id = GOOD_ID;
    push_attempts(1);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    pulse_recheck();
    check("t6_restart_busy", 80'({busy, check_done, id_mismatch}), 80'(3'b100));
    wait_done(100);
    @(posedge clock);
    #1;
    check("t6_periph_rise", 80'(periph_reset_n), 80'(1));

    // recheck after a pass keeps the peripheral out of reset.
    push_attempts(1);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    pulse_recheck();
    check("t6_periph_kept", 80'({periph_reset_n, busy}), 80'(2'b11));
    wait_done(100);

    // Timestamp wrong for two attempts; recheck pulses while busy are ignored.
    ts_bad_attempts = 2;
    push_attempts(3);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    do_reset();
    repeat (14) @(posedge clock);
    check("t3_busy_at_recheck1", 80'(busy), 80'(1));
    pulse_recheck();
    repeat (24) @(posedge clock);
    check("t3_busy_at_recheck2", 80'(busy), 80'(1));
    pulse_recheck();
    wait_done(300);
    @(negedge clock);
    check("t3_id_reads", 80'(id_reads), 80'(3));
    ts_bad_attempts = 0;

    // ID read stalled for 300 cycles: timeout, retry, then pass.
    push_attempts(1);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    do_reset();
    waitrequest = 1'b1;
    fork
      begin
        repeat (300) @(posedge clock);
        #1;
        waitrequest = 1'b0;
      end
    join_none
    stalls = 0;
    n = 0;
    while (!timeout && n < 400) begin
      @(negedge clock);
      n++;
      if (!timeout && sysid_read && waitrequest) stalls++;
    end
    check("t4_timeout_seen", 80'(timeout), 80'(1));
    check("t4_stalled_cycles", 80'(stalls), 80'(255));
    check("t4_read_dropped", 80'({sysid_read, busy}), 80'(2'b01));
    wait_done(400);

    // Asynchronous reset during LAT_TS, then a clean restart.
    push_attempts(2);
    exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS));
    do_reset();
    n = 0;
    while (dbg_state != ST_LAT_TS && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t5_reached_lat_ts", 80'(dbg_state), 80'(ST_LAT_TS));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_outputs", all_outputs(), 80'(0));
    check("t5_async_state", 80'(dbg_state), 80'(ST_START));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t5_restart_rd_id", 80'({dbg_state, sysid_read, sysid_address}),
          80'({ST_RD_ID, 1'b1, SYSID_ADDR_ID}));
    wait_done(100);
    @(negedge clock);

    check("addr_q_drained", 80'(exp_addr_q.size()), 80'(0));
    check("res_q_drained", 80'(exp_res_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
